// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_if
// Description : Request/response bundle between a producer and instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [63:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_instr;
    logic              err;
    logic [7:0]        err_count;

    modport master (
        output in_valid, op, rd, rn, rm, imm, out_ready,
        input  in_ready, out_valid, out_addr, out_instr, err, err_count
    );

    modport slave (
        input  in_valid, op, rd, rn, rm, imm, out_ready,
        output in_ready, out_valid, out_addr, out_instr, err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs op/register fields and a range-checked signed immediate
//               into LEGv8 words written at sequential byte addresses.
//               Macro INSTR_ENCODER_ERR_FILL_EN: rejected requests emit a
//               filler word (ADD X31,X31,X31) instead of being dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    instr_encoder_if.slave bus
);
    localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
    localparam logic [31:0]       FILL_WORD = 32'h8B1F03FF;
    localparam logic [10:0]       OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0]       OPC_STUR  = 11'b11111000000;
    localparam logic [7:0]        OPC_CBZ   = 8'b10110100;
    localparam logic [10:0]       OPC_ADD   = 11'b10001011000;
    localparam logic [10:0]       OPC_SUB   = 11'b11001011000;
    localparam logic [10:0]       OPC_AND   = 11'b10001010000;
    localparam logic [10:0]       OPC_ORR   = 11'b10101010000;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              w_out_valid;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_xfer;
    logic              w_legal;
    logic              w_emit;
    logic [31:0]       w_word;
    logic [31:0]       w_load_word;

    assign w_out_valid = (state_q == FULL);
    assign w_in_ready  = ~reset & ~clear & (~w_out_valid | bus.out_ready);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_xfer      = w_out_valid & bus.out_ready;

    // Legality mirrors decode's sign extension: the dropped upper bits must
    // all equal the sign bit of the field that survives truncation.
    always_comb begin : encode
        w_word  = '0;
        w_legal = 1'b0;
        case (bus.op)
            3'd0, 3'd1: begin
                w_legal = (bus.imm[63:8] == {56{bus.imm[8]}});
                w_word  = {(bus.op == 3'd0) ? OPC_LDUR : OPC_STUR,
                           bus.imm[8:0], 2'b00, bus.rn, bus.rd};
            end
            3'd2: begin
                w_legal = (bus.imm[63:18] == {46{bus.imm[18]}});
                w_word  = {OPC_CBZ, bus.imm[18:0], bus.rd};
            end
            3'd3: begin
                w_legal = 1'b1;
                w_word  = {OPC_ADD, bus.rm, 6'b0, bus.rn, bus.rd};
            end
            3'd4: begin
                w_legal = 1'b1;
                w_word  = {OPC_SUB, bus.rm, 6'b0, bus.rn, bus.rd};
            end
            3'd5: begin
                w_legal = 1'b1;
                w_word  = {OPC_AND, bus.rm, 6'b0, bus.rn, bus.rd};
            end
            3'd6: begin
                w_legal = 1'b1;
                w_word  = {OPC_ORR, bus.rm, 6'b0, bus.rn, bus.rd};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = '0;
            end
        endcase
    end

`ifdef INSTR_ENCODER_ERR_FILL_EN
    assign w_emit      = w_accept;
    assign w_load_word = w_legal ? w_word : FILL_WORD;
`else
    assign w_emit      = w_accept & w_legal;
    assign w_load_word = w_word;
`endif

    always_comb begin : next_state
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (w_xfer) begin
            addr_d = addr_q + ADDR_W'(4);
        end
        if (w_accept && !w_legal) begin
            err_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        if (w_emit) begin
            instr_d = w_load_word;
        end
        case (state_q)
            EMPTY:   if (w_emit) state_d = FULL;
            FULL:    if (w_xfer && !w_emit) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= EMPTY;
            addr_q  <= BASE;
            instr_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_addr  = addr_q;
    assign bus.out_instr = instr_q;
    assign bus.err       = err_q;
    assign bus.err_count = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed and randomized self-checking bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
    localparam int          ADDR_W = 4;
    localparam logic [31:0] FILL   = 32'h8B1F03FF;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int o, input int d, input int n,
                         input int m, input longint i);
        bus.in_valid = v;
        bus.op       = 3'(o);
        bus.rd       = 5'(d);
        bus.rn       = 5'(n);
        bus.rm       = 5'(m);
        bus.imm      = i;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        clear = 1'b0;
    endtask

    // Reference encoding built from numeric ranges and field offsets.
    function automatic void ref_encode(input int op, input int rd, input int rn,
                                       input int rm, input longint imm,
                                       output logic [31:0] w, output bit ok);
        longint t;
        longint opc;
        t = 0;
        ok = 1'b0;
        case (op)
            0, 1: begin
                ok  = (imm >= -256) && (imm <= 255);
                opc = (op == 0) ? 'h7C2 : 'h7C0;
                t   = (opc << 21) | ((imm & 'h1FF) << 12) | (longint'(rn) << 5) | longint'(rd);
            end
            2: begin
                ok = (imm >= -262144) && (imm <= 262143);
                t  = ('hB4 << 24) | ((imm & 'h7FFFF) << 5) | longint'(rd);
            end
            3, 4, 5, 6: begin
                ok  = 1'b1;
                opc = (op == 3) ? 'h458 : (op == 4) ? 'h658 : (op == 5) ? 'h450 : 'h550;
                t   = (opc << 21) | (longint'(rm) << 16) | (longint'(rn) << 5) | longint'(rd);
            end
            default: ok = 1'b0;
        endcase
        w = t[31:0];
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        clear = 1'b0;
        bus.out_ready = 1'b0;
        drive(1, 3, 1, 1, 1, 0);
        tick();
        tick();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_addr !== 4'd0) begin errors++; $display("FAIL reset_out_addr got %0d exp 0", bus.out_addr); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 0", bus.out_instr); end
        checks++; if (bus.err !== 1'b0 || bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %b/%0d exp 0/0", bus.err, bus.err_count); end
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_ldur;
        bus.out_ready = 1'b0;
        drive(1, 0, 1, 2, 0, 251);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ldur_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'hF84FB041) begin errors++; $display("FAIL ldur_instr got %h exp F84FB041", bus.out_instr); end
        checks++; if (bus.out_addr !== 4'd0) begin errors++; $display("FAIL ldur_addr got %0d exp 0", bus.out_addr); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 4'd4) begin errors++; $display("FAIL ldur_xfer got v=%b a=%0d exp v=0 a=4", bus.out_valid, bus.out_addr); end
    endtask

    task automatic test_back_to_back;
        do_clear();
        bus.out_ready = 1'b1;
        drive(1, 1, 3, 4, 0, -5);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hF81FB083 || bus.out_addr !== 4'd0) begin
            errors++; $display("FAIL b2b_stur got v=%b %h @%0d exp 1 F81FB083 @0", bus.out_valid, bus.out_instr, bus.out_addr); end
        drive(1, 3, 3, 1, 2, 0);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h8B020023 || bus.out_addr !== 4'd4) begin
            errors++; $display("FAIL b2b_add got v=%b %h @%0d exp 1 8B020023 @4", bus.out_valid, bus.out_instr, bus.out_addr); end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 4'd8) begin errors++; $display("FAIL b2b_drain got v=%b a=%0d exp v=0 a=8", bus.out_valid, bus.out_addr); end
    endtask

    task automatic test_cbz_range;
        do_clear();
        bus.out_ready = 1'b1;
        drive(1, 2, 5, 0, 0, -1);
        tick();
        checks++; if (bus.out_instr !== 32'hB4FFFFE5 || bus.out_addr !== 4'd0) begin errors++; $display("FAIL cbz_instr got %h @%0d exp B4FFFFE5 @0", bus.out_instr, bus.out_addr); end
        drive(1, 2, 5, 0, 0, 262144);
        tick();
        checks++; if (bus.err !== 1'b1 || bus.err_count !== 8'd1) begin errors++; $display("FAIL cbz_reject_err got %b/%0d exp 1/1", bus.err, bus.err_count); end
`ifdef INSTR_ENCODER_ERR_FILL_EN
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== FILL || bus.out_addr !== 4'd4) begin
            errors++; $display("FAIL cbz_reject_fill got v=%b %h @%0d exp 1 %h @4", bus.out_valid, bus.out_instr, bus.out_addr, FILL); end
`else
        checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 4'd4) begin errors++; $display("FAIL cbz_reject_drop got v=%b @%0d exp 0 @4", bus.out_valid, bus.out_addr); end
`endif
        drive(1, 3, 3, 1, 2, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
`ifdef INSTR_ENCODER_ERR_FILL_EN
        checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 4'd8) begin errors++; $display("FAIL cbz_next_addr got v=%b @%0d exp 1 @8", bus.out_valid, bus.out_addr); end
`else
        checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 4'd4) begin errors++; $display("FAIL cbz_next_addr got v=%b @%0d exp 1 @4", bus.out_valid, bus.out_addr); end
`endif
        tick();
    endtask

    task automatic test_stall;
        do_clear();
        bus.out_ready = 1'b0;
        drive(1, 3, 3, 1, 2, 0);
        tick();
        drive(1, 4, 1, 2, 3, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h8B020023 || bus.out_addr !== 4'd0 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold cyc%0d got v=%b %h @%0d rdy=%b", i, bus.out_valid, bus.out_instr, bus.out_addr, bus.in_ready); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", bus.in_ready); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hCB030041 || bus.out_addr !== 4'd4) begin
            errors++; $display("FAIL stall_next got v=%b %h @%0d exp 1 CB030041 @4", bus.out_valid, bus.out_instr, bus.out_addr); end
        tick();
    endtask

    task automatic test_wrap;
        do_clear();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 3, i, 0, 0, 0);
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 4'((4 * i) % 16)) begin
                errors++; $display("FAIL wrap_addr word%0d got v=%b @%0d exp 1 @%0d", i, bus.out_valid, bus.out_addr, (4 * i) % 16); end
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_clear;
        do_clear();
        bus.out_ready = 1'b1;
        drive(1, 7, 0, 0, 0, 0);
        tick();
        drive(1, 3, 1, 1, 1, 0);
        tick();
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.out_valid !== 1'b1 || bus.err_count !== 8'd1) begin errors++; $display("FAIL clear_setup got v=%b cnt=%0d exp 1/1", bus.out_valid, bus.err_count); end
        clear = 1'b1;
        drive(1, 3, 2, 2, 2, 0);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got %b exp 0", bus.in_ready); end
        tick();
        clear = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 4'd0 || bus.err !== 1'b0 || bus.err_count !== 8'd0) begin
            errors++; $display("FAIL clear_state got v=%b @%0d err=%b cnt=%0d exp 0 @0 0 0", bus.out_valid, bus.out_addr, bus.err, bus.err_count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clear_req_dropped got v=%b exp 0", bus.out_valid); end
    endtask

    task automatic test_saturate;
        do_clear();
        bus.out_ready = 1'b1;
        drive(1, 7, 0, 0, 0, 0);
        repeat (255) tick();
        checks++; if (bus.err_count !== 8'd255 || bus.err !== 1'b1) begin errors++; $display("FAIL sat_255 got %b/%0d exp 1/255", bus.err, bus.err_count); end
        repeat (5) tick();
        checks++; if (bus.err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", bus.err_count); end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random;
        bit          m_valid;
        logic [31:0] m_instr;
        int          m_addr;
        bit          m_err;
        int          m_cnt;
        bit          exp_rdy;
        logic [31:0] w;
        bit          ok;
        int          op;
        longint      imm;
        longint      bnd[8] = '{255, 256, -256, -257, 262143, 262144, -262144, -262145};
        do_clear();
        m_valid = 0; m_instr = 0; m_addr = 0; m_err = 0; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            checks++; if (bus.out_valid !== m_valid || bus.out_addr !== 4'(m_addr) || (m_valid && bus.out_instr !== m_instr)) begin
                errors++; $display("FAIL rnd_out cyc%0d got v=%b %h @%0d exp v=%b %h @%0d", c, bus.out_valid, bus.out_instr, bus.out_addr, m_valid, m_instr, m_addr); end
            checks++; if (bus.err !== m_err || bus.err_count !== 8'(m_cnt)) begin
                errors++; $display("FAIL rnd_err cyc%0d got %b/%0d exp %b/%0d", c, bus.err, bus.err_count, m_err, m_cnt); end
            op = int'($urandom_range(0, 7));
            case ($urandom % 5)
                0: imm = longint'($urandom_range(0, 511)) - 256;
                1: imm = bnd[$urandom % 8];
                2: imm = {$urandom, $urandom};
                3: imm = longint'($urandom_range(0, 524287)) - 262144;
                default: imm = longint'($urandom_range(0, 20));
            endcase
            drive(($urandom % 4) != 0, op, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32), imm);
            bus.out_ready = (($urandom % 4) != 0);
            clear = (($urandom % 150) == 0);
            #1;
            exp_rdy = !clear && (!m_valid || bus.out_ready);
            checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc%0d got %b exp %b", c, bus.in_ready, exp_rdy); end
            if (clear) begin
                m_valid = 0; m_instr = 0; m_addr = 0; m_err = 0; m_cnt = 0;
            end else begin
                if (m_valid && bus.out_ready) begin
                    m_valid = 0;
                    m_addr  = (m_addr + 4) % (1 << ADDR_W);
                end
                if (bus.in_valid && exp_rdy) begin
                    ref_encode(op, int'(bus.rd), int'(bus.rn), int'(bus.rm), imm, w, ok);
                    if (ok) begin
                        m_valid = 1; m_instr = w;
                    end else begin
                        m_err = 1;
                        if (m_cnt < 255) m_cnt++;
`ifdef INSTR_ENCODER_ERR_FILL_EN
                        m_valid = 1; m_instr = FILL;
`endif
                    end
                end
            end
            tick();
            clear = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_ldur();
        test_back_to_back();
        test_cbz_range();
        test_stall();
        test_wrap();
        test_clear();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Instruction encoder: packs an operation class, register fields and a 64-bit signed immediate into a 32-bit LEGv8 instruction word.
- Writes the encoded stream to instruction memory at sequential word addresses.
- It is the inverse of the immediate sign-extension path in the decode stage: it range-checks and truncates the immediate that decode later sign-extends.
- Used by the program loader and by benches to build instruction memory images.

Parameters:
ADDR_W, 10, width of the output byte address; wraps modulo 2^ADDR_W
BASE_ADDR, 0, byte address of the first instruction after reset or clear; must be a multiple of 4

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous restart: address to BASE_ADDR, counters and err cleared
in_valid  in  1  encode request valid
in_ready  out  1  encoder can accept a request this cycle
op  in  3  0 LDUR, 1 STUR, 2 CBZ, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 illegal
rd  in  5  Rd (R-format) / Rt (D-format, CBZ)
rn  in  5  Rn (R-format, D-format)
rm  in  5  Rm (R-format)
imm  in  64  signed immediate: DT_address (D-format) or word offset (CBZ); ignored for R-format
out_valid  out  1  encoded word valid
out_ready  in  1  memory accepts word
out_addr  out  ADDR_W  byte address of out_instr
out_instr  out  32  encoded instruction
err  out  1  sticky: at least one request was rejected
err_count  out  8  number of rejected requests, saturates at 255

Behaviour:
- Reset (or clear): out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_count=0. A pending output word is discarded.
- in_ready = ~reset & ~clear & (~out_valid | out_ready).
- Accept when in_valid & in_ready; the registered result appears the next cycle (1-cycle latency).
- out_valid/out_instr/out_addr hold stable while out_valid & ~out_ready.
- Transfer occurs on out_valid & out_ready; address advances by 4 after each transfer, wrapping modulo 2^ADDR_W.
- Simultaneous transfer and accept: new word loaded the same edge at the incremented address; full throughput of 1 word/cycle.
- Field encodings:
  - LDUR: {11'b11111000010, imm[8:0], 2'b00, rn, rd}
  - STUR: {11'b11111000000, imm[8:0], 2'b00, rn, rd}
  - CBZ: {8'b10110100, imm[18:0], rd}
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: {opc, rm, 6'b0, rn, rd}
- Range rule:
  - D-format requires imm[63:8] all equal to imm[8] (-256..255).
  - CBZ requires imm[63:18] all equal to imm[18].
- Rejection: an out-of-range immediate or op=7 is still accepted (handshake completes) but produces no output word. err is set, err_count is incremented (saturating), and the address does not advance.
- clear and in_valid in the same cycle: clear wins; the request is not accepted (in_ready=0).
- Internal FSM: EMPTY (out_valid=0), FULL (out_valid=1).
  - EMPTY -> FULL on a valid in-range accept.
  - FULL -> EMPTY on transfer without a new valid accept.
  - FULL -> FULL on transfer plus accept, or while stalled.
  - reset/clear -> EMPTY.

Optional Feature:
INSTR_ENCODER_ERR_FILL_EN
- Defined: a rejected request emits a filler word 32'h8B1F03FF (ADD X31,X31,X31) at the next address, with normal handshake and address advance, so image addresses stay aligned to request order. err/err_count still update.
- Undefined: rejected requests are dropped as above.

Test Plan:
- LDUR rd=1 rn=2 imm=251 -> next cycle out_valid=1, out_instr=32'hF84FB041, out_addr=0.
- STUR rd=3 rn=4 imm=-5, then ADD rd=3 rn=1 rm=2 back-to-back with out_ready=1 -> words 32'hF81FB083 @0 and 32'h8B020023 @4 on consecutive cycles.
- CBZ rd=5 imm=-1 -> 32'hB4FFFFE5; CBZ imm=262144 -> rejected, err=1, err_count=1, no out_valid, next valid word still @ the unadvanced address (filler 32'h8B1F03FF at that address when INSTR_ENCODER_ERR_FILL_EN is defined).
- Word pending, out_ready=0 for 3 cycles -> out_valid, out_instr, out_addr stable and in_ready=0; out_ready=1 -> transfer, in_ready=1 same cycle.
- ADDR_W=4: issue 5 accepted words -> addresses 0,4,8,12,0 (wrap).
- Word pending, then clear pulsed with in_valid=1 -> out_valid=0, out_addr=BASE_ADDR, err_count=0, request not accepted.
